// File: rtl/mem_port_arbiter_if.sv
// Signal bundle tying the fetch port, the data port and the shared memory port
// to mem_port_arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned MASK_W = DATA_W / 8;

    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_req_ready;
    logic              if_resp_valid;
    logic [DATA_W-1:0] if_resp_data;

    logic              d_req_valid;
    logic              d_req_we;
    logic [ADDR_W-1:0] d_req_addr;
    logic [DATA_W-1:0] d_req_wdata;
    logic [MASK_W-1:0] d_req_wmask;
    logic              d_req_ready;
    logic              d_resp_valid;
    logic [DATA_W-1:0] d_resp_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [MASK_W-1:0] mem_req_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    logic              busy;

    // Arbiter's view: serves the pipeline requesters, drives the memory port.
    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_resp_valid, if_resp_data,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wmask,
        output d_req_ready, d_resp_valid, d_resp_data,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output busy
    );

    // Surrounding system's view: pipeline requesters plus the memory responder.
    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_resp_valid, if_resp_data,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wmask,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data-path requests onto the single memory port, one
// transaction outstanding, with a starvation limit protecting fetch.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              owner_d_q, owner_d_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic              mem_req_we_q, mem_req_we_d;
    logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
    logic [DATA_W-1:0] mem_req_wdata_q, mem_req_wdata_d;
    logic [MASK_W-1:0] mem_req_wmask_q, mem_req_wmask_d;
    logic              if_resp_valid_q, if_resp_valid_d;
    logic [DATA_W-1:0] if_resp_data_q, if_resp_data_d;
    logic              d_resp_valid_q, d_resp_valid_d;
    logic [DATA_W-1:0] d_resp_data_d, d_resp_data_q;
    logic              busy_q, busy_d;
    logic              grant_if_c, grant_d_c;

    // Next-state, arbitration and output computation.
    always_comb begin
        state_d         = state_q;
        starve_cnt_d    = starve_cnt_q;
        owner_d_d       = owner_d_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_we_d    = mem_req_we_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_wdata_d = mem_req_wdata_q;
        mem_req_wmask_d = mem_req_wmask_q;
        if_resp_valid_d = 1'b0;
        if_resp_data_d  = if_resp_data_q;
        d_resp_valid_d  = 1'b0;
        d_resp_data_d   = d_resp_data_q;
        grant_if_c      = 1'b0;
        grant_d_c       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // D has priority unless fetch has waited through STARVE_MAX D grants.
                grant_if_c = bus.if_req_valid &&
                             (!bus.d_req_valid || (starve_cnt_q == CNT_MAX));
                grant_d_c  = bus.d_req_valid && !grant_if_c;
                if (!bus.if_req_valid) begin
                    starve_cnt_d = '0;
                end
                if (grant_if_c) begin
                    starve_cnt_d    = '0;
                    owner_d_d       = 1'b0;
                    mem_req_we_d    = 1'b0;
                    mem_req_addr_d  = bus.if_req_addr;
                    mem_req_wdata_d = '0;
                    mem_req_wmask_d = '0;
                    mem_req_valid_d = 1'b1;
                    state_d         = ST_ISSUE;
                end else if (grant_d_c) begin
                    if (bus.if_req_valid && (starve_cnt_q != CNT_MAX)) begin
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    end
                    owner_d_d       = 1'b1;
                    mem_req_we_d    = bus.d_req_we;
                    mem_req_addr_d  = bus.d_req_addr;
                    mem_req_wdata_d = bus.d_req_wdata;
                    mem_req_wmask_d = bus.d_req_wmask;
                    mem_req_valid_d = 1'b1;
                    state_d         = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    if (mem_req_we_q) begin
                        d_resp_valid_d = 1'b1;
                        d_resp_data_d  = '0;
                        state_d        = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.mem_resp_valid) begin
                    if (owner_d_q) begin
                        d_resp_valid_d = 1'b1;
                        d_resp_data_d  = bus.mem_resp_data;
                    end else begin
                        if_resp_valid_d = 1'b1;
                        if_resp_data_d  = bus.mem_resp_data;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                mem_req_valid_d = 1'b0;
                state_d         = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            starve_cnt_q    <= '0;
            owner_d_q       <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_we_q    <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_wdata_q <= '0;
            mem_req_wmask_q <= '0;
            if_resp_valid_q <= 1'b0;
            if_resp_data_q  <= '0;
            d_resp_valid_q  <= 1'b0;
            d_resp_data_q   <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            starve_cnt_q    <= starve_cnt_d;
            owner_d_q       <= owner_d_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_we_q    <= mem_req_we_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_wdata_q <= mem_req_wdata_d;
            mem_req_wmask_q <= mem_req_wmask_d;
            if_resp_valid_q <= if_resp_valid_d;
            if_resp_data_q  <= if_resp_data_d;
            d_resp_valid_q  <= d_resp_valid_d;
            d_resp_data_q   <= d_resp_data_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.if_req_ready  = grant_if_c;
    assign bus.d_req_ready   = grant_d_c;
    assign bus.if_resp_valid = if_resp_valid_q;
    assign bus.if_resp_data  = if_resp_data_q;
    assign bus.d_resp_valid  = d_resp_valid_q;
    assign bus.d_resp_data   = d_resp_data_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_we    = mem_req_we_q;
    assign bus.mem_req_addr  = mem_req_addr_q;
    assign bus.mem_req_wdata = mem_req_wdata_q;
    assign bus.mem_req_wmask = mem_req_wmask_q;
    assign bus.busy          = busy_q;
endmodule
